// File: rtl/emg_beacon_pkg.sv
// Shared widths, RX state encoding and helpers for the emergency beacon receiver.
package emg_beacon_pkg;

    localparam int LANE_W     = 3;
    localparam int HOLD_W     = 4;
    localparam int FRAME_BITS = 9;
    localparam int LEFT_W     = 7;
    localparam int LANES      = 1 << LANE_W;

    typedef enum logic [1:0] {
        IDLE,
        LANE,
        HOLD,
        PARITY
    } rx_state_t;

    function automatic logic [LEFT_W-1:0] hold_cycles(input logic [HOLD_W-1:0] hold,
                                                      input int scale);
        return LEFT_W'(hold) * LEFT_W'(scale);
    endfunction

    function automatic logic [LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
        return LANES'(1) << lane;
    endfunction

endpackage

// File: rtl/emg_beacon_rx_if.sv
// Beacon bit stream in, emergency request out; master = radio front end side, slave = receiver.
interface emg_beacon_rx_if;

    logic                             bitValid;
    logic                             bitData;
    logic                             emgSignal;
    logic [emg_beacon_pkg::LANES-1:0] emgLane;
    logic [emg_beacon_pkg::LEFT_W-1:0] holdLeft;
    logic                             frameErr;
    logic                             dropped;

    modport master (
        output bitValid, bitData,
        input  emgSignal, emgLane, holdLeft, frameErr, dropped
    );

    modport slave (
        input  bitValid, bitData,
        output emgSignal, emgLane, holdLeft, frameErr, dropped
    );

endinterface

// File: rtl/emg_frame_deserializer.sv
// Serial beacon frame receiver: start bit, lane, hold, even parity, with inter-bit timeout.
//
// state  | meaning
// IDLE   | waiting for a start bit (bitData=1); zero bits are ignored
// LANE   | collecting the 3 lane bits
// HOLD   | collecting the 4 hold bits
// PARITY | waiting for the parity bit; frame_valid is combinational on its accept cycle
module emg_frame_deserializer
    import emg_beacon_pkg::*;
#(
    parameter int BIT_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_valid,
    input  logic              bit_data,
    output logic              frame_valid,
    output logic [LANE_W-1:0] lane,
    output logic [HOLD_W-1:0] hold,
    output logic              frame_err
);

    localparam int SR_W  = FRAME_BITS - 2;
    localparam int GAP_W = (BIT_TIMEOUT > 1) ? $clog2(BIT_TIMEOUT) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(BIT_TIMEOUT - 1);

    if (BIT_TIMEOUT < 1) begin : g_bad_timeout
        $error("BIT_TIMEOUT must be at least 1");
    end

    rx_state_t         state, state_nxt;
    logic [1:0]        cnt, cnt_nxt;
    logic [SR_W-1:0]   sr, sr_nxt;
    logic [GAP_W-1:0]  gap, gap_nxt;
    logic              err_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            gap       <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sr        <= sr_nxt;
            gap       <= gap_nxt;
            frame_err <= err_nxt;
        end
    end

    // Gap is a down-counter reloaded on every accepted bit; expiring at zero
    // means BIT_TIMEOUT idle cycles have elapsed since the last bit.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        sr_nxt      = sr;
        gap_nxt     = gap;
        err_nxt     = 1'b0;
        frame_valid = 1'b0;
        case (state)
            IDLE: begin
                if (bit_valid && bit_data) begin
                    state_nxt = LANE;
                    cnt_nxt   = '0;
                    gap_nxt   = GAP_LOAD;
                end
            end
            default: begin
                if (bit_valid) begin
                    gap_nxt = GAP_LOAD;
                    cnt_nxt = cnt + 2'd1;
                    if (state == PARITY) begin
                        state_nxt = IDLE;
                        if (^{sr, bit_data}) err_nxt = 1'b1;
                        else                 frame_valid = 1'b1;
                    end else begin
                        sr_nxt = {sr[SR_W-2:0], bit_data};
                        if (state == LANE && cnt == 2'd2) begin
                            state_nxt = HOLD;
                            cnt_nxt   = '0;
                        end
                        if (state == HOLD && cnt == 2'd3) begin
                            state_nxt = PARITY;
                            cnt_nxt   = '0;
                        end
                    end
                end else if (gap == '0) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end else begin
                    gap_nxt = gap - GAP_W'(1);
                end
            end
        endcase
    end

    assign lane = sr[SR_W-1 -: LANE_W];
    assign hold = sr[HOLD_W-1:0];

endmodule

// File: rtl/emg_beacon_rx.sv
// Emergency beacon receiver: turns validated frames into a timed one-hot lane request.
// Define EMG_QUEUE_EN to hold one different-lane request pending until the active one ends.
module emg_beacon_rx
    import emg_beacon_pkg::*;
#(
    parameter int HOLD_SCALE  = 4,
    parameter int BIT_TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          rst,
    emg_beacon_rx_if.slave bus
);

    if (HOLD_SCALE < 1 || HOLD_SCALE * 15 > 127) begin : g_bad_hold_scale
        $error("HOLD_SCALE must be in 1..8 so hold*HOLD_SCALE fits in holdLeft");
    end

    logic              frame_valid;
    logic [LANE_W-1:0] f_lane;
    logic [HOLD_W-1:0] f_hold;
    logic              frame_err;

    emg_frame_deserializer #(
        .BIT_TIMEOUT(BIT_TIMEOUT)
    ) u_deser (
        .clk        (clk),
        .rst        (rst),
        .bit_valid  (bus.bitValid),
        .bit_data   (bus.bitData),
        .frame_valid(frame_valid),
        .lane       (f_lane),
        .hold       (f_hold),
        .frame_err  (frame_err)
    );

    logic              active, active_nxt;
    logic [LANES-1:0]  lane_oh, lane_nxt;
    logic [LEFT_W-1:0] left, left_nxt;
    logic              drop, drop_nxt;
    logic              live, expiring, load, release_req;
    logic [LANE_W-1:0] load_lane;
    logic [HOLD_W-1:0] load_hold;

`ifdef EMG_QUEUE_EN
    logic              pend_valid, pend_valid_nxt;
    logic [LANE_W-1:0] pend_lane, pend_lane_nxt;
    logic [HOLD_W-1:0] pend_hold, pend_hold_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid <= 1'b0;
            pend_lane  <= '0;
            pend_hold  <= '0;
        end else begin
            pend_valid <= pend_valid_nxt;
            pend_lane  <= pend_lane_nxt;
            pend_hold  <= pend_hold_nxt;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active  <= 1'b0;
            lane_oh <= '0;
            left    <= '0;
            drop    <= 1'b0;
        end else begin
            active  <= active_nxt;
            lane_oh <= lane_nxt;
            left    <= left_nxt;
            drop    <= drop_nxt;
        end
    end

    // A request on its last cycle counts as already finished, so any frame
    // arriving then is handled as if the receiver were inactive.
    always_comb begin
        expiring    = active && (left == LEFT_W'(1));
        live        = active && !expiring;
        load        = 1'b0;
        load_lane   = f_lane;
        load_hold   = f_hold;
        release_req = expiring;
        drop_nxt    = 1'b0;
`ifdef EMG_QUEUE_EN
        pend_valid_nxt = pend_valid;
        pend_lane_nxt  = pend_lane;
        pend_hold_nxt  = pend_hold;
`endif
        if (frame_valid) begin
            if (live && lane_onehot(f_lane) == lane_oh) begin
                if (f_hold != '0) load = 1'b1;
                else              release_req = 1'b1;
            end else if (live) begin
`ifdef EMG_QUEUE_EN
                if (f_hold == '0 || pend_valid) drop_nxt = 1'b1;
                if (f_hold != '0) begin
                    pend_valid_nxt = 1'b1;
                    pend_lane_nxt  = f_lane;
                    pend_hold_nxt  = f_hold;
                end
`else
                drop_nxt = 1'b1;
`endif
            end else if (f_hold != '0) begin
                load = 1'b1;
            end
        end
`ifdef EMG_QUEUE_EN
        if (!load && release_req && pend_valid) begin
            load           = 1'b1;
            load_lane      = pend_lane;
            load_hold      = pend_hold;
            pend_valid_nxt = 1'b0;
        end
`endif

        active_nxt = active;
        lane_nxt   = lane_oh;
        left_nxt   = left;
        if (load) begin
            active_nxt = 1'b1;
            lane_nxt   = lane_onehot(load_lane);
            left_nxt   = hold_cycles(load_hold, HOLD_SCALE);
        end else if (release_req) begin
            active_nxt = 1'b0;
            lane_nxt   = '0;
            left_nxt   = '0;
        end else if (active) begin
            left_nxt = left - LEFT_W'(1);
        end
    end

    assign bus.emgSignal = active;
    assign bus.emgLane   = lane_oh;
    assign bus.holdLeft  = left;
    assign bus.frameErr  = frame_err;
    assign bus.dropped   = drop;

endmodule

// File: tb/tb_emg_beacon_rx.sv
// Directed bench for emg_beacon_rx; inputs change and outputs are sampled on the falling edge.
module tb_emg_beacon_rx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   high_cnt;

    emg_beacon_rx_if bus ();

    emg_beacon_rx #(
        .HOLD_SCALE (4),
        .BIT_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.bitValid = 1'b1;
        bus.bitData  = b;
        @(negedge clk);
        bus.bitValid = 1'b0;
        bus.bitData  = 1'b0;
    endtask

    task automatic send_frame(input logic [2:0] lane, input logic [3:0] hold, input logic flip);
        logic [8:0] fr;
        fr = {1'b1, lane, hold, (^{lane, hold}) ^ flip};
        for (int i = 8; i >= 0; i--) send_bit(fr[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.bitValid = 1'b0;
        bus.bitData  = 1'b0;
        idle(2);
        chk("rst_sig", bus.emgSignal, 0);
        chk("rst_lane", bus.emgLane, 0);
        chk("rst_left", bus.holdLeft, 0);
        chk("rst_err", bus.frameErr, 0);
        chk("rst_drop", bus.dropped, 0);
        rst = 1'b1;
        idle(1);

        // zeros in IDLE are ignored, then lane 2 hold 3 -> 12 cycles
        send_bit(1'b0);
        send_bit(1'b0);
        send_frame(3'd2, 4'd3, 1'b0);
        chk("a_sig", bus.emgSignal, 1);
        chk("a_lane", bus.emgLane, 8'h04);
        chk("a_left", bus.holdLeft, 12);
        high_cnt = 0;
        while (bus.emgSignal === 1'b1 && high_cnt < 50) begin
            high_cnt++;
            @(negedge clk);
        end
        chk("a_high_cycles", high_cnt, 12);
        chk("a_lane_off", bus.emgLane, 0);
        chk("a_left_off", bus.holdLeft, 0);

        // refresh at holdLeft=5, reload after expiry, then cancel
        send_frame(3'd2, 4'd4, 1'b0);
        chk("b_left16", bus.holdLeft, 16);
        idle(3);
        send_frame(3'd2, 4'd2, 1'b0);
        chk("b_refresh_left", bus.holdLeft, 8);
        chk("b_refresh_lane", bus.emgLane, 8'h04);
        send_frame(3'd2, 4'd3, 1'b0);
        chk("b_reload_left", bus.holdLeft, 12);
        chk("b_reload_sig", bus.emgSignal, 1);
        send_frame(3'd2, 4'd0, 1'b0);
        chk("b_cancel_sig", bus.emgSignal, 0);
        chk("b_cancel_lane", bus.emgLane, 0);
        chk("b_cancel_left", bus.holdLeft, 0);
        send_frame(3'd3, 4'd0, 1'b0);
        chk("b_idle_hold0_sig", bus.emgSignal, 0);
        chk("b_idle_hold0_drop", bus.dropped, 0);

        // different-lane frame landing on the expiry cycle is a new request
        send_frame(3'd2, 4'd3, 1'b0);
        idle(3);
        send_frame(3'd6, 4'd1, 1'b0);
        chk("c_sig", bus.emgSignal, 1);
        chk("c_lane", bus.emgLane, 8'h40);
        chk("c_left", bus.holdLeft, 4);
        chk("c_drop", bus.dropped, 0);
        idle(4);
        chk("c_expired", bus.emgSignal, 0);

        // parity error
        send_frame(3'd5, 4'd1, 1'b1);
        chk("d_err", bus.frameErr, 1);
        chk("d_sig", bus.emgSignal, 0);
        chk("d_drop", bus.dropped, 0);
        idle(1);
        chk("d_err_pulse", bus.frameErr, 0);

        // start + 4 bits, then timeout after 8 idle cycles
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        idle(7);
        chk("e_err_early", bus.frameErr, 0);
        idle(1);
        chk("e_err", bus.frameErr, 1);
        idle(1);
        chk("e_err_pulse", bus.frameErr, 0);
        send_frame(3'd1, 4'd1, 1'b0);
        chk("e_lane", bus.emgLane, 8'h02);
        chk("e_left", bus.holdLeft, 4);
        idle(4);
        chk("e_expired", bus.emgSignal, 0);

        // lane 0 active, lane 6 frame arrives
        send_frame(3'd0, 4'd5, 1'b0);
        send_frame(3'd6, 4'd2, 1'b0);
        chk("f_lane", bus.emgLane, 8'h01);
        chk("f_left", bus.holdLeft, 11);
`ifdef EMG_QUEUE_EN
        chk("f_drop_q", bus.dropped, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("f_q_sig", bus.emgSignal, 1);
        end
        @(negedge clk);
        chk("f_q_sig_switch", bus.emgSignal, 1);
        chk("f_q_lane", bus.emgLane, 8'h40);
        chk("f_q_left", bus.holdLeft, 8);
        idle(1);
`else
        chk("f_drop", bus.dropped, 1);
        idle(1);
        chk("f_drop_pulse", bus.dropped, 0);
        chk("f_lane_kept", bus.emgLane, 8'h01);
        idle(3);
`endif
        chk("g_left7", bus.holdLeft, 7);

        // asynchronous reset mid-hold
        rst = 1'b0;
        #1;
        chk("g_rst_sig", bus.emgSignal, 0);
        chk("g_rst_lane", bus.emgLane, 0);
        chk("g_rst_left", bus.holdLeft, 0);
        @(negedge clk);
        rst = 1'b1;
        idle(1);

        // asynchronous reset mid-frame, then a clean frame
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b0;
        #1;
        chk("g_rst2_err", bus.frameErr, 0);
        chk("g_rst2_sig", bus.emgSignal, 0);
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        send_frame(3'd7, 4'd1, 1'b0);
        chk("g_new_lane", bus.emgLane, 8'h80);
        chk("g_new_left", bus.holdLeft, 4);
        chk("g_new_err", bus.frameErr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
